instr_cache_sa: RTL

- Parametrised set-associative instruction cache; next generation of the dummy reset-only ICache.
- Sits between the fetch stage and the memory/L2 port.
- Does tag lookup with 1-cycle hit latency.
- Handles misses with a blocking line-refill FSM, per-set round-robin replacement, and whole-cache flush.

---
 rtl/instr_cache_sa_if.sv | 42 ++++
 rtl/instr_cache_sa.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_sa_if.sv
// Fetch-side and memory-side signal bundle for instr_cache_sa.
// ICACHE_PERF_CNT_EN adds the hit/miss counter outputs.
interface instr_cache_sa_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned FETCH_BYTES = 8,
    parameter int unsigned MEM_BYTES   = 8
);
    logic [PC_WIDTH-1:0]      i_pc;
    logic                     i_read;
    logic                     o_ready;
    logic                     o_valid;
    logic [FETCH_BYTES*8-1:0] o_data;
    logic                     o_miss;
    logic                     i_flush;
    logic                     o_mem_req;
    logic [PC_WIDTH-1:0]      o_mem_addr;
    logic                     i_mem_ack;
    logic                     i_mem_rvalid;
    logic [MEM_BYTES*8-1:0]   i_mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]              o_hit_cnt;
    logic [31:0]              o_miss_cnt;
`endif

    // Cache side.
    modport slave (
        input  i_pc, i_read, i_flush, i_mem_ack, i_mem_rvalid, i_mem_rdata,
`ifdef ICACHE_PERF_CNT_EN
        output o_hit_cnt, o_miss_cnt,
`endif
        output o_ready, o_valid, o_data, o_miss, o_mem_req, o_mem_addr
    );

    // Fetch stage / memory side.
    modport master (
        output i_pc, i_read, i_flush, i_mem_ack, i_mem_rvalid, i_mem_rdata,
`ifdef ICACHE_PERF_CNT_EN
        input  o_hit_cnt, o_miss_cnt,
`endif
        input  o_ready, o_valid, o_data, o_miss, o_mem_req, o_mem_addr
    );
endinterface

// File: rtl/instr_cache_sa.sv
// Set-associative instruction cache: 1-cycle hit lookup, blocking line refill,
// per-set round-robin replacement, whole-cache flush. ICACHE_PERF_CNT_EN adds hit/miss counters.
module instr_cache_sa #(
    parameter int unsigned ASSOC       = 2,
    parameter int unsigned SETS        = 64,
    parameter int unsigned LINE_BYTES  = 32,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned FETCH_BYTES = 8,
    parameter int unsigned MEM_BYTES   = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    instr_cache_sa_if.slave  bus
);
    localparam int unsigned OFF_W    = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W    = $clog2(SETS);
    localparam int unsigned TAG_W    = PC_WIDTH - OFF_W - IDX_W;
    localparam int unsigned WAY_W    = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int unsigned BEATS    = LINE_BYTES / MEM_BYTES;
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WORDS    = LINE_BYTES / FETCH_BYTES;
    localparam int unsigned FB_SHIFT = $clog2(FETCH_BYTES);
    localparam int unsigned LINE_W   = LINE_BYTES * 8;
    localparam int unsigned FETCH_W  = FETCH_BYTES * 8;
    localparam int unsigned MEM_W    = MEM_BYTES * 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_REQ    = 2'd2;
    localparam logic [1:0] S_FILL   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [OFF_W-1:0]    off;

    logic [ASSOC-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]    tag_q   [ASSOC][SETS];
    logic [LINE_W-1:0]   data_q  [ASSOC][SETS];
    logic [WAY_W-1:0]    rr_q    [SETS];

    logic [WAY_W-1:0]    victim, victim_q;
    logic                victim_valid, victim_was_valid_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                flush_pend_q;
    logic                mem_req_q;
    logic [PC_WIDTH-1:0] mem_addr_q;

    logic                hit;
    logic [LINE_W-1:0]   hit_line;
    logic [FETCH_W-1:0]  hit_word;
    logic                accept, clear_all, start_req, fill_we, last_beat, commit;
    logic                hit_resp, lookup_miss;

    assign idx = pc_q[OFF_W +: IDX_W];
    assign tag = pc_q[PC_WIDTH-1 -: TAG_W];
    assign off = pc_q[OFF_W-1:0];

    function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
        if (32'(p) == ASSOC - 1) return '0;
        return p + WAY_W'(1);
    endfunction

    // Tag compare across ways; matches are ORed, then the fetch word is picked from the line.
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
                hit      = 1'b1;
                hit_line = hit_line | data_q[w][idx];
            end
        end
        hit_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (i == int'(off >> FB_SHIFT)) hit_word = hit_line[i*FETCH_W +: FETCH_W];
        end
    end

    // Lowest-numbered invalid way, otherwise the set's round-robin way.
    always_comb begin
        victim       = rr_q[idx];
        victim_valid = 1'b1;
        for (int w = int'(ASSOC) - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim       = WAY_W'(w);
                victim_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        clear_all   = 1'b0;
        start_req   = 1'b0;
        fill_we     = 1'b0;
        commit      = 1'b0;
        hit_resp    = 1'b0;
        lookup_miss = 1'b0;
        last_beat   = (beat_q == BEAT_W'(BEATS - 1));
        case (state_q)
            S_IDLE: begin
                if (bus.i_flush) begin
                    clear_all = 1'b1;
                end else if (bus.i_read) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (bus.i_flush) begin
                    clear_all = 1'b1;
                    state_d   = S_IDLE;
                end else if (hit) begin
                    hit_resp = 1'b1;
                    if (bus.i_read) accept  = 1'b1;
                    else            state_d = S_IDLE;
                end else begin
                    lookup_miss = 1'b1;
                    start_req   = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.i_mem_ack) state_d = S_FILL;
            end
            S_FILL: begin
                if (bus.i_mem_rvalid) begin
                    fill_we = 1'b1;
                    if (last_beat) begin
                        // A flush seen during the refill drops the line and the stale request.
                        if (flush_pend_q || bus.i_flush) begin
                            clear_all = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            commit  = 1'b1;
                            state_d = S_LOOKUP;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q               <= '0;
            victim_q           <= '0;
            victim_was_valid_q <= 1'b0;
            beat_q             <= '0;
            flush_pend_q       <= 1'b0;
            mem_req_q          <= 1'b0;
            mem_addr_q         <= '0;
        end else begin
            if (accept) pc_q <= bus.i_pc;
            if (start_req) begin
                victim_q           <= victim;
                victim_was_valid_q <= victim_valid;
                beat_q             <= '0;
                flush_pend_q       <= 1'b0;
                mem_req_q          <= 1'b1;
                mem_addr_q         <= {pc_q[PC_WIDTH-1:OFF_W], OFF_W'(0)};
            end
            if ((state_q == S_REQ) && bus.i_mem_ack) mem_req_q <= 1'b0;
            if (((state_q == S_REQ) || (state_q == S_FILL)) && bus.i_flush) flush_pend_q <= 1'b1;
            if (fill_we) beat_q <= beat_q + BEAT_W'(1);
        end
    end

    // Valid bits and RR pointers; the pointer moves only when a valid line is replaced.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (clear_all) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (commit) begin
            valid_q[idx][victim_q] <= 1'b1;
            if (victim_was_valid_q) rr_q[idx] <= rr_next(rr_q[idx]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (fill_we) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_q == BEAT_W'(k)) data_q[victim_q][idx][k*MEM_W +: MEM_W] <= bus.i_mem_rdata;
            end
        end
        if (commit) tag_q[victim_q][idx] <= tag;
    end

    assign bus.o_ready    = (state_q == S_IDLE) || ((state_q == S_LOOKUP) && hit);
    assign bus.o_valid    = hit_resp;
    assign bus.o_miss     = lookup_miss;
    assign bus.o_data     = hit_resp ? hit_word : '0;
    assign bus.o_mem_req  = mem_req_q;
    assign bus.o_mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_resp)    hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.o_hit_cnt  = hit_cnt_q;
    assign bus.o_miss_cnt = miss_cnt_q;
`endif
endmodule
